parking_car_emulator: RTL and testbench

Sensor-side stimulus generator for the parking-lot occupancy counter. It converts single-cycle "car enters" and "car exits" requests into the two-sensor blocking sequence that the counter decodes. It drives `a_low`/`b_low` with the same active-low polarity as the physical buttons, so its outputs connect directly to the debouncer inputs. It also keeps its own occupancy model, so hardware self-test can compare the model against the counter's display value.

---
 rtl/parking_car_emulator.sv | 223 ++++++++++++++++++++++
 tb/tb_parking_car_emulator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_car_emulator.sv
// ---------------------------------------------------------------------------
// ParkingCarEmulator (module parking_car_emulator)
//
// Purpose:
//    Sensor-side stimulus generator for the parking-lot occupancy counter.
//    A single-cycle enter or exit request becomes the four-phase two-sensor
//    blocking sequence that the counter decodes. The sensor outputs are
//    active-low, like the physical buttons, so they can feed the debouncer
//    inputs directly. The block also keeps its own occupancy model, which
//    hardware self-test can compare against the counter's display value.
//
// Parameters:
//    PHASE_CYCLES  clock cycles each sensor phase is held (must exceed the
//                  debounce time; default 2_500_000 = 50 ms at 50 MHz)
//    CAP           maximum occupancy, 1..15
//
// Ports:
//    clk        in   clock
//    rst_n      in   asynchronous, active-low reset
//    req_enter  in   request one entering car (sampled every cycle)
//    req_exit   in   request one exiting car (sampled every cycle)
//    a_low      out  sensor a, active-low (0 = blocked), registered
//    b_low      out  sensor b, active-low (0 = blocked), registered
//    busy       out  a sequence is in progress
//    done       out  one-cycle tick when a sequence completes
//    err        out  one-cycle tick when a request is refused
//    occ        out  model occupancy
//
// Configuration macro:
//    CAR_OCC_GUARD_EN  when defined, an enter at occ == CAP and an exit at
//                      occ == 0 are refused with an err tick. When undefined,
//                      every single request is accepted and occ wraps
//                      modulo 16, matching the counter's mod-16 behaviour.
// ---------------------------------------------------------------------------
module parking_car_emulator #(
   parameter int unsigned PHASE_CYCLES = 2_500_000,
   parameter int unsigned CAP          = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_enter,
   input  logic       req_exit,
   output logic       a_low,
   output logic       b_low,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] occ
);

   // A one-cycle phase still needs a one-bit counter.
   localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);
   localparam logic [3:0]    CAP_OCC    = 4'(CAP);

`ifdef CAR_OCC_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      P1,
      P2,
      P3,
      GAP
   } state_t;

   state_t        state_q,    state_d;
   logic [CW-1:0] phaseCnt_q, phaseCnt_d;
   logic          dir_q,      dir_d;
   logic [3:0]    occ_q,      occ_d;
   logic          aLow_q,     aLow_d;
   logic          bLow_q,     bLow_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;
   logic          err_q,      err_d;

   logic onlyEnter;
   logic onlyExit;
   logic enterOk;
   logic exitOk;
   logic refuse;
   logic phaseEnd;
   logic aBlocked;
   logic bBlocked;

   // Request qualification. Simultaneous requests are always refused. With
   // the guard enabled, an enter at capacity or an exit from an empty lot is
   // refused as well; without it the guard terms are constant-false.
   always_comb begin
      onlyEnter = req_enter & ~req_exit;
      onlyExit  = req_exit & ~req_enter;
      enterOk   = onlyEnter & ~(GUARD_EN & (occ_q == CAP_OCC));
      exitOk    = onlyExit  & ~(GUARD_EN & (occ_q == 4'd0));
      refuse    = (req_enter & req_exit)
                | (onlyEnter & ~enterOk)
                | (onlyExit  & ~exitOk);
   end

   // Sequencer. Every non-idle state is held for exactly PHASE_CYCLES cycles
   // using a counter that restarts at zero on each phase boundary. The
   // occupancy model changes only when GAP completes, so a sequence cut
   // short by reset never touches occ.
   always_comb begin
      state_d    = state_q;
      phaseCnt_d = phaseCnt_q;
      dir_d      = dir_q;
      occ_d      = occ_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      phaseEnd   = (phaseCnt_q == PHASE_LAST);

      if (state_q != IDLE) begin
         phaseCnt_d = phaseEnd ? '0 : phaseCnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            phaseCnt_d = '0;
            if (enterOk) begin
               state_d = P1;
               dir_d   = 1'b0;
            end else if (exitOk) begin
               state_d = P1;
               dir_d   = 1'b1;
            end else if (refuse) begin
               err_d = 1'b1;
            end
         end
         P1: begin
            if (phaseEnd) begin
               state_d = P2;
            end
         end
         P2: begin
            if (phaseEnd) begin
               state_d = P3;
            end
         end
         P3: begin
            if (phaseEnd) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (phaseEnd) begin
               state_d = IDLE;
               done_d  = 1'b1;
               occ_d   = dir_q ? (occ_q - 4'd1) : (occ_q + 4'd1);
            end
         end
         default: begin
            state_d    = IDLE;
            phaseCnt_d = '0;
         end
      endcase
   end

   // Sensor levels are decoded from the *next* state so the registered
   // outputs change on the same edge as the state. Enter blocks a first,
   // exit blocks b first; the middle phase blocks both. Consecutive phases
   // differ in only one sensor, so a and b never toggle together.
   always_comb begin
      aBlocked = 1'b0;
      bBlocked = 1'b0;
      case (state_d)
         P1: begin
            aBlocked = ~dir_d;
            bBlocked = dir_d;
         end
         P2: begin
            aBlocked = 1'b1;
            bBlocked = 1'b1;
         end
         P3: begin
            aBlocked = dir_d;
            bBlocked = ~dir_d;
         end
         default: begin
            aBlocked = 1'b0;
            bBlocked = 1'b0;
         end
      endcase
      aLow_d = ~aBlocked;
      bLow_d = ~bBlocked;
      busy_d = (state_d != IDLE);
   end

   // State and output registers. Reset releases both sensors (high = clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phaseCnt_q <= '0;
         dir_q      <= 1'b0;
         occ_q      <= 4'd0;
         aLow_q     <= 1'b1;
         bLow_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phaseCnt_q <= phaseCnt_d;
         dir_q      <= dir_d;
         occ_q      <= occ_d;
         aLow_q     <= aLow_d;
         bLow_q     <= bLow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign a_low = aLow_q;
   assign b_low = bLow_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign occ   = occ_q;

endmodule

// File: tb/tb_parking_car_emulator.sv
// ---------------------------------------------------------------------------
// tb_parking_car_emulator
//
// Self-checking bench for parking_car_emulator with PHASE_CYCLES = 4.
// A behavioural model counts cycles since a request was accepted and derives
// the sensor phase as elapsed / PHASE_CYCLES; a compare process checks every
// DUT output against it on each falling clock edge while out of reset.
// Directed scenarios pin the model with literal expectations, then a
// randomized request stream runs against the model. Build with
// +define+CAR_OCC_GUARD_EN to exercise the guarded configuration.
// ---------------------------------------------------------------------------
module tb_parking_car_emulator;

   localparam int PC   = 4;
   localparam int CAPV = 15;

`ifdef CAR_OCC_GUARD_EN
   localparam bit GUARDED = 1'b1;
`else
   localparam bit GUARDED = 1'b0;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       req_enter = 1'b0;
   logic       req_exit  = 1'b0;
   logic       a_low;
   logic       b_low;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] occ;

   int checks    = 0;
   int passes    = 0;
   int doneSeen  = 0;
   int errSeen   = 0;

   parking_car_emulator #(
      .PHASE_CYCLES(PC),
      .CAP         (CAPV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_enter(req_enter),
      .req_exit (req_exit),
      .a_low    (a_low),
      .b_low    (b_low),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .occ      (occ)
   );

   // 10-unit clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
   always #5 clk = ~clk;

   // Reference model: a sequence is just "busy for 4*PC edges after the
   // accepting edge"; the phase is the elapsed count divided by PC.
   bit         mBusy    = 1'b0;
   bit         mDir     = 1'b0;
   bit         mDone    = 1'b0;
   bit         mErr     = 1'b0;
   int         mElapsed = 0;
   logic [3:0] mOcc     = 4'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy    = 1'b0;
         mDir     = 1'b0;
         mDone    = 1'b0;
         mErr     = 1'b0;
         mElapsed = 0;
         mOcc     = 4'd0;
      end else begin
         mDone = 1'b0;
         mErr  = 1'b0;
         if (mBusy) begin
            mElapsed++;
            if (mElapsed == 4 * PC) begin
               mBusy = 1'b0;
               mDone = 1'b1;
               mOcc  = mDir ? mOcc - 4'd1 : mOcc + 4'd1;
            end
         end else if (req_enter && req_exit) begin
            mErr = 1'b1;
         end else if (req_enter || req_exit) begin
            if (GUARDED && ((req_enter && mOcc == 4'(CAPV)) || (req_exit && mOcc == 4'd0))) begin
               mErr = 1'b1;
            end else begin
               mBusy    = 1'b1;
               mDir     = req_exit;
               mElapsed = 0;
            end
         end
      end
   end

   // Expected {a_low, b_low}: the car blocks its leading sensor, then both,
   // then the trailing sensor, then neither.
   function automatic logic [1:0] expLow();
      logic [1:0] blk;
      if (!mBusy) return 2'b11;
      case (mElapsed / PC)
         0:       blk = mDir ? 2'b01 : 2'b10;
         1:       blk = 2'b11;
         2:       blk = mDir ? 2'b10 : 2'b01;
         default: blk = 2'b00;
      endcase
      return ~blk;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("sensors", {6'd0, a_low, b_low}, {6'd0, expLow()});
         checkOutput("busy",    {7'd0, busy}, {7'd0, mBusy});
         checkOutput("done",    {7'd0, done}, {7'd0, mDone});
         checkOutput("err",     {7'd0, err},  {7'd0, mErr});
         checkOutput("occ",     {4'd0, occ},  {4'd0, mOcc});
      end
   end

   // Pulse tallies used by the directed scenarios.
   always @(negedge clk) begin
      if (rst_n && done === 1'b1) doneSeen++;
      if (rst_n && err === 1'b1) errSeen++;
   end

   // Called on a falling edge; holds the request for one cycle and returns
   // on the next falling edge (first cycle after the sampling edge).
   task automatic applyStimulus(input logic enter, input logic leave);
      req_enter = enter;
      req_exit  = leave;
      @(negedge clk);
      req_enter = 1'b0;
      req_exit  = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("waitIdle", {7'd0, busy}, 8'd0);
   endtask

   // Literal sensor sequence for one full sequence, then done/occ at cycle 17.
   task automatic checkPattern(input bit isExit, input logic [3:0] occAfter);
      logic [1:0] pat [4];
      if (isExit) pat = '{2'b10, 2'b00, 2'b01, 2'b11};
      else        pat = '{2'b01, 2'b00, 2'b10, 2'b11};
      for (int i = 0; i < 4 * PC; i++) begin
         checkOutput(isExit ? "exitPattern" : "enterPattern", {6'd0, a_low, b_low}, {6'd0, pat[i / PC]});
         @(negedge clk);
      end
      checkOutput("patDone", {7'd0, done}, 8'd1);
      checkOutput("patBusy", {7'd0, busy}, 8'd0);
      checkOutput("patOcc",  {4'd0, occ},  {4'd0, occAfter});
   endtask

   initial begin
      #1  rst_n = 1'b0;
      #22 rst_n = 1'b1;
      @(negedge clk);

      // Reset state.
      checkOutput("rstSensors", {6'd0, a_low, b_low}, 8'h03);
      checkOutput("rstBusy",    {7'd0, busy}, 8'd0);
      checkOutput("rstDone",    {7'd0, done}, 8'd0);
      checkOutput("rstErr",     {7'd0, err},  8'd0);
      checkOutput("rstOcc",     {4'd0, occ},  8'd0);

      // 1: single enter.
      $display("[TB] scenario 1: enter");
      applyStimulus(1'b1, 1'b0);
      checkPattern(1'b0, 4'd1);

      // 2: back-to-back exit.
      $display("[TB] scenario 2: exit");
      applyStimulus(1'b0, 1'b1);
      checkPattern(1'b1, 4'd0);

      // 3: simultaneous requests.
      $display("[TB] scenario 3: simultaneous requests");
      applyStimulus(1'b1, 1'b1);
      checkOutput("bothErr",  {7'd0, err},  8'd1);
      checkOutput("bothBusy", {7'd0, busy}, 8'd0);
      checkOutput("bothOcc",  {4'd0, occ},  8'd0);
      @(negedge clk);
      checkOutput("bothErrLen", {7'd0, err}, 8'd0);

      // 4: exit requests during P2 of an enter are ignored.
      $display("[TB] scenario 4: requests while busy");
      doneSeen = 0;
      errSeen  = 0;
      applyStimulus(1'b1, 1'b0);
      repeat (PC) @(negedge clk);
      req_exit = 1'b1;
      repeat (PC) @(negedge clk);
      req_exit = 1'b0;
      waitIdle(40);
      @(negedge clk);
      checkOutput("busyDones", 8'(doneSeen), 8'd1);
      checkOutput("busyErrs",  8'(errSeen),  8'd0);
      checkOutput("busyOcc",   {4'd0, occ},  8'd1);

      // 5a: fill to capacity, then one more enter.
      $display("[TB] scenario 5a: enter at capacity");
      for (int i = 1; i < CAPV; i++) begin
         applyStimulus(1'b1, 1'b0);
         waitIdle(40);
      end
      checkOutput("fullOcc", {4'd0, occ}, 8'd15);
      applyStimulus(1'b1, 1'b0);
      if (GUARDED) begin
         checkOutput("capErr",  {7'd0, err},  8'd1);
         checkOutput("capBusy", {7'd0, busy}, 8'd0);
         for (int i = 0; i < 3; i++) begin
            checkOutput("capSensors", {6'd0, a_low, b_low}, 8'h03);
            @(negedge clk);
         end
         checkOutput("capOcc", {4'd0, occ}, 8'd15);
      end else begin
         waitIdle(40);
         checkOutput("wrapUpOcc", {4'd0, occ}, 8'd0);
      end

      // 6: reset during P3 of an exit sequence, then clean sequences.
      $display("[TB] scenario 6: reset mid-sequence");
      applyStimulus(1'b0, 1'b1);
      repeat (2 * PC + 1) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstSensors", {6'd0, a_low, b_low}, 8'h03);
      checkOutput("midRstBusy",    {7'd0, busy}, 8'd0);
      checkOutput("midRstDone",    {7'd0, done}, 8'd0);
      checkOutput("midRstOcc",     {4'd0, occ},  8'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0);
      checkPattern(1'b0, 4'd1);
      applyStimulus(1'b0, 1'b1);
      waitIdle(40);
      checkOutput("postRstOcc", {4'd0, occ}, 8'd0);

      // 5b: exit from an empty lot.
      $display("[TB] scenario 5b: exit when empty");
      applyStimulus(1'b0, 1'b1);
      if (GUARDED) begin
         checkOutput("emptyErr",  {7'd0, err},  8'd1);
         checkOutput("emptyBusy", {7'd0, busy}, 8'd0);
         checkOutput("emptyOcc",  {4'd0, occ},  8'd0);
      end else begin
         waitIdle(40);
         checkOutput("wrapDownOcc", {4'd0, occ}, 8'd15);
      end

      // Randomized request stream checked by the model every cycle.
      $display("[TB] random phase");
      for (int i = 0; i < 1200; i++) begin
         req_enter = ($urandom_range(0, 5) == 0);
         req_exit  = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      req_enter = 1'b0;
      req_exit  = 1'b0;
      waitIdle(40);
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #400000;
      $display("[TB] FAIL timeout: simulation ran past its time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
